// File: rtl/alarm_controller.sv
// Alarm ring/snooze/stop controller: detects the running time reaching the stored
// alarm time, rings with a 1 Hz beep, and handles snooze, stop and auto-timeout.
module alarm_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZES = 3
) (
    input  logic       clk,
    input  logic       alarm_reset,
    input  logic       sec_tick,
    input  logic [5:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [5:0] alm_hr,
    input  logic [5:0] alm_min,
    input  logic       alarm_en,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer,
    output logic       alarm_fired,
    output logic [2:0] snooze_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
    localparam logic [7:0] RING_SAT  = 8'(RING_SECS);
    localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SECS - 1);
    localparam logic [9:0] SNZ_SAT   = 10'(SNOOZE_SECS);
    localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZES);

    state_t     state;
    logic       eq;
    logic       eq_q;
    logic       match_rise;
    logic       beep_phase;
    logic [7:0] ring_cnt;
    logic [9:0] snz_timer;

    // Edge-detect the time match so an event fires once, not for the whole minute.
    assign eq         = (cur_hr == alm_hr) && (cur_min == alm_min);
    assign match_rise = eq & ~eq_q;

    always_ff @(posedge clk or negedge alarm_reset) begin
        if (!alarm_reset) begin
            state       <= IDLE;
            eq_q        <= 1'b0;
            beep_phase  <= 1'b0;
            ring_cnt    <= '0;
            snz_timer   <= '0;
            snooze_cnt  <= '0;
            alarm_fired <= 1'b0;
        end else begin
            eq_q        <= eq;
            alarm_fired <= 1'b0;
            if (!alarm_en) begin
                state      <= IDLE;
                ring_cnt   <= '0;
                snz_timer  <= '0;
                snooze_cnt <= '0;
                beep_phase <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (match_rise) begin
                            state       <= RING;
                            ring_cnt    <= '0;
                            snooze_cnt  <= '0;
                            beep_phase  <= 1'b1;
                            alarm_fired <= 1'b1;
                        end
                    end
                    RING: begin
                        if (stop_btn) begin
                            state <= IDLE;
                        end else if (snooze_btn && (snooze_cnt < SNZ_MAX)) begin
                            state      <= SNOOZE;
                            snz_timer  <= '0;
                            snooze_cnt <= snooze_cnt + 3'd1;
                        end else if (sec_tick) begin
                            beep_phase <= ~beep_phase;
                            if (ring_cnt >= RING_LAST) begin
                                state    <= IDLE;
                                ring_cnt <= RING_SAT;
                            end else begin
                                ring_cnt <= ring_cnt + 8'd1;
                            end
                        end
                    end
                    SNOOZE: begin
                        if (stop_btn) begin
                            state <= IDLE;
                        end else if (sec_tick) begin
                            if (snz_timer >= SNZ_LAST) begin
                                // Re-ring is not a new event, so alarm_fired stays low.
                                state      <= RING;
                                snz_timer  <= SNZ_SAT;
                                ring_cnt   <= '0;
                                beep_phase <= 1'b1;
                            end else begin
                                snz_timer <= snz_timer + 10'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ringing   = (state == RING);
    assign snoozing  = (state == SNOOZE);
    assign buzzer    = ringing & beep_phase;
    assign dbg_state = state;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: stimulus pushes expected output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_alarm_controller;

    logic       clk;
    logic       alarm_reset;
    logic       sec_tick;
    logic [5:0] cur_hr, cur_min, alm_hr, alm_min;
    logic       alarm_en, stop_btn, snooze_btn;
    logic       ringing, snoozing, buzzer, alarm_fired;
    logic [2:0] snooze_cnt;
    logic [1:0] dbg_state;

    localparam logic [1:0] S_IDLE = 2'd0, S_RING = 2'd1, S_SNZ = 2'd2;

    alarm_controller #(.RING_SECS(4), .SNOOZE_SECS(3), .MAX_SNOOZES(2)) dut (
        .clk(clk), .alarm_reset(alarm_reset), .sec_tick(sec_tick),
        .cur_hr(cur_hr), .cur_min(cur_min), .alm_hr(alm_hr), .alm_min(alm_min),
        .alarm_en(alarm_en), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer),
        .alarm_fired(alarm_fired), .snooze_cnt(snooze_cnt), .dbg_state(dbg_state)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: {state, fired, ringing, snoozing, buzzer, snooze_cnt}
    logic [8:0] exp_q[$];
    string      name_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [8:0] exp_v, act_v;
    string      nm;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {dbg_state, alarm_fired, ringing, snoozing, buzzer, snooze_cnt};
            tests_run++;
            if (act_v !== exp_v) begin
                tests_failed++;
                $display("FAIL %s: got st/fired/ring/snz/buz/cnt=%b expected %b", nm, act_v, exp_v);
            end
        end
    end

    // driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        sec_tick = 1'b1; cyc(1); sec_tick = 1'b0;
    endtask

    task automatic snooze();
        snooze_btn = 1'b1; cyc(1); snooze_btn = 1'b0;
    endtask

    task automatic stop();
        stop_btn = 1'b1; cyc(1); stop_btn = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [1:0] st, input logic f,
                              input logic r, input logic s, input logic b, input logic [2:0] c);
        exp_q.push_back({st, f, r, s, b, c});
        name_q.push_back(name);
    endtask

    // Forces a fresh match_rise by stepping cur_min away from and back to the alarm minute.
    task automatic rise_at_30();
        cur_min = 6'd31; cyc(1);
        cur_min = 6'd30; cyc(1);
    endtask

    initial begin
        alarm_reset = 1'b0; sec_tick = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
        alarm_en = 1'b0;
        cur_hr = 6'd7; cur_min = 6'd29; alm_hr = 6'd7; alm_min = 6'd30;
        cyc(2);
        expect_out("reset_state", S_IDLE, 0, 0, 0, 0, 3'd0);
        alarm_reset = 1'b1;
        cyc(2);

        // 1: fire, 1 Hz beep, timeout after 4 ticks, no re-fire while still 07:30
        alarm_en = 1'b1;
        cur_min = 6'd30; cyc(1);
        expect_out("t1_fire", S_RING, 1, 1, 0, 1, 3'd0);
        cyc(1);
        expect_out("t1_fire_once", S_RING, 0, 1, 0, 1, 3'd0);
        tick(); expect_out("t1_tick1_buz0", S_RING, 0, 1, 0, 0, 3'd0);
        tick(); expect_out("t1_tick2_buz1", S_RING, 0, 1, 0, 1, 3'd0);
        tick(); expect_out("t1_tick3_buz0", S_RING, 0, 1, 0, 0, 3'd0);
        tick(); expect_out("t1_timeout", S_IDLE, 0, 0, 0, 0, 3'd0);
        tick(); cyc(2);
        expect_out("t1_no_refire", S_IDLE, 0, 0, 0, 0, 3'd0);

        // 2: snooze, re-ring, snooze limit
        rise_at_30();
        expect_out("t2_fire", S_RING, 1, 1, 0, 1, 3'd0);
        snooze(); expect_out("t2_snooze1", S_SNZ, 0, 0, 1, 0, 3'd1);
        tick(); tick(); expect_out("t2_snz_wait", S_SNZ, 0, 0, 1, 0, 3'd1);
        tick(); expect_out("t2_rering1", S_RING, 0, 1, 0, 1, 3'd1);
        snooze(); expect_out("t2_snooze2", S_SNZ, 0, 0, 1, 0, 3'd2);
        tick(); tick(); tick(); expect_out("t2_rering2", S_RING, 0, 1, 0, 1, 3'd2);
        snooze(); expect_out("t2_snooze_ignored", S_RING, 0, 1, 0, 1, 3'd2);
        tick(); expect_out("t2_tick_after_ign", S_RING, 0, 1, 0, 0, 3'd2);
        stop(); expect_out("t2_stop", S_IDLE, 0, 0, 0, 0, 3'd2);

        // 3: stop and snooze together while ringing, stop wins
        rise_at_30();
        expect_out("t3_fire_cnt_clr", S_RING, 1, 1, 0, 1, 3'd0);
        snooze(); tick(); tick(); tick();
        expect_out("t3_rering", S_RING, 0, 1, 0, 1, 3'd1);
        stop_btn = 1'b1; snooze_btn = 1'b1; cyc(1); stop_btn = 1'b0; snooze_btn = 1'b0;
        expect_out("t3_stop_wins", S_IDLE, 0, 0, 0, 0, 3'd1);

        // 4: alarm_en dropped mid-snooze
        rise_at_30();
        expect_out("t4_fire", S_RING, 1, 1, 0, 1, 3'd0);
        snooze(); tick();
        expect_out("t4_snoozing", S_SNZ, 0, 0, 1, 0, 3'd1);
        alarm_en = 1'b0; cyc(1);
        expect_out("t4_en_off", S_IDLE, 0, 0, 0, 0, 3'd0);
        tick(); tick(); tick();
        expect_out("t4_no_rering", S_IDLE, 0, 0, 0, 0, 3'd0);

        // 5: alarm register write produces a rise; none when disabled
        cur_hr = 6'd6; cur_min = 6'd0; alm_hr = 6'd6; alm_min = 6'd59; alarm_en = 1'b1;
        cyc(2);
        expect_out("t5_idle", S_IDLE, 0, 0, 0, 0, 3'd0);
        alm_min = 6'd0; cyc(1);
        expect_out("t5_write_fire", S_RING, 1, 1, 0, 1, 3'd0);
        stop();
        alarm_en = 1'b0; alm_min = 6'd59; cyc(1);
        alm_min = 6'd0; cyc(1);
        expect_out("t5_disabled_no_fire", S_IDLE, 0, 0, 0, 0, 3'd0);
        alarm_en = 1'b1; cyc(2);
        expect_out("t5_enable_no_rise", S_IDLE, 0, 0, 0, 0, 3'd0);

        // 6: asynchronous reset mid-ring
        alm_min = 6'd59; cyc(1);
        alm_min = 6'd0; cyc(1);
        expect_out("t6_fire", S_RING, 1, 1, 0, 1, 3'd0);
        tick();
        expect_out("t6_ringing", S_RING, 0, 1, 0, 0, 3'd0);
        @(posedge clk);
        #2;
        alarm_reset = 1'b0;
        cur_min = 6'd1;
        expect_out("t6_async_clear", S_IDLE, 0, 0, 0, 0, 3'd0);
        #5;
        alarm_reset = 1'b1;
        cyc(2);
        expect_out("t6_idle_after_rst", S_IDLE, 0, 0, 0, 0, 3'd0);
        cur_min = 6'd0; cyc(1);
        expect_out("t6_next_rise", S_RING, 1, 1, 0, 1, 3'd0);

        // final report
        cyc(2);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
